// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the cpu run/halt/step sequencer.
// Encodings of run_state_t are visible on the state port.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        HALTED     = 2'd1,
        RUNNING    = 2'd2,
        STEPPING   = 2'd3
    } run_state_t;

    localparam int INSTR_CNT_W = 32;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer: holds the cpu in reset, then gates its clock enable.
// Optional retired-instruction counter via CPU_RUN_CTRL_INSTR_CNT_EN.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int RST_CYCLES = 4,
    parameter int AUTO_RUN   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              soft_rst_req,
    input  logic              bp_valid,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic              cpu_instr_done,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic              bp_hit
`ifdef CPU_RUN_CTRL_INSTR_CNT_EN
    ,
    output logic [INSTR_CNT_W-1:0] instr_count
`endif
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

    run_state_t       st, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pend, pend_nxt;
    logic             bp_nxt;
    logic             done;
    logic             halt_now;
    logic             bp_match;

    // Retirement only counts while the cpu is actually enabled.
    assign done     = cpu_instr_done & cpu_en;
    assign halt_now = halt_req | pend;
    assign bp_match = bp_valid && (cpu_pc == bp_addr);
    assign state    = st;

    always_comb begin
        nxt      = st;
        cnt_nxt  = cnt;
        pend_nxt = pend;
        bp_nxt   = bp_hit;
        if (soft_rst_req) begin
            nxt      = RESET_HOLD;
            cnt_nxt  = '0;
            pend_nxt = 1'b0;
        end else begin
            unique case (st)
                RESET_HOLD: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt = '0;
                        nxt     = (AUTO_RUN != 0) ? RUNNING : HALTED;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                HALTED: begin
                    if (step_req) begin
                        nxt    = STEPPING;
                        bp_nxt = 1'b0;
                    end else if (run_req) begin
                        nxt    = RUNNING;
                        bp_nxt = 1'b0;
                    end
                end
                RUNNING: begin
                    // A pending halt wins over a breakpoint on the same retirement.
                    if (done && halt_now) begin
                        nxt = HALTED;
                    end else if (done && bp_match) begin
                        nxt    = HALTED;
                        bp_nxt = 1'b1;
                    end else if (halt_req) begin
                        pend_nxt = 1'b1;
                    end
                end
                STEPPING: begin
                    if (done) nxt = HALTED;
                end
                default: nxt = RESET_HOLD;
            endcase
        end
        if (nxt == HALTED) pend_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st      <= RESET_HOLD;
            cnt     <= '0;
            pend    <= 1'b0;
            bp_hit  <= 1'b0;
            cpu_rst <= 1'b1;
            cpu_en  <= 1'b0;
        end else begin
            st      <= nxt;
            cnt     <= cnt_nxt;
            pend    <= pend_nxt;
            bp_hit  <= bp_nxt;
            cpu_rst <= (nxt == RESET_HOLD);
            cpu_en  <= (nxt == RUNNING) || (nxt == STEPPING);
        end
    end

`ifdef CPU_RUN_CTRL_INSTR_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count <= '0;
        end else if (soft_rst_req) begin
            instr_count <= '0;
        end else if (done) begin
            instr_count <= instr_count + INSTR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl (AUTO_RUN=0, RST_CYCLES=4).
// Expected output vectors are queued with each stimulus and popped after the edge.
module tb_cpu_run_ctrl;
    import cpu_ctrl_pkg::*;

    typedef struct packed {
        logic        run;
        logic        halt;
        logic        step;
        logic        srst;
        logic        done;
        logic [15:0] pc;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_req, halt_req, step_req, soft_rst_req;
    logic        bp_valid;
    logic [15:0] bp_addr, cpu_pc;
    logic        cpu_instr_done;
    logic        cpu_rst, cpu_en, bp_hit;
    logic [1:0]  state;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    stim_t      stim_q[$];
    logic [4:0] exp_q[$];

    cpu_run_ctrl #(.ADDR_W(16), .RST_CYCLES(4), .AUTO_RUN(0)) dut (
        .clk(clk),
        .rst(rst),
        .run_req(run_req),
        .halt_req(halt_req),
        .step_req(step_req),
        .soft_rst_req(soft_rst_req),
        .bp_valid(bp_valid),
        .bp_addr(bp_addr),
        .cpu_pc(cpu_pc),
        .cpu_instr_done(cpu_instr_done),
        .cpu_rst(cpu_rst),
        .cpu_en(cpu_en),
        .state(state),
        .bp_hit(bp_hit)
`ifdef CPU_RUN_CTRL_INSTR_CNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

`ifndef CPU_RUN_CTRL_INSTR_CNT_EN
    assign instr_count = '0;
`endif

    always #5 clk = ~clk;

    function automatic stim_t mk(logic r, logic h, logic s, logic sr, logic d,
                                 logic [15:0] pc);
        mk = '{run: r, halt: h, step: s, srst: sr, done: d, pc: pc};
    endfunction

    function automatic logic [4:0] ex(run_state_t s, logic r, logic en, logic bp);
        ex = {s, r, en, bp};
    endfunction

    task automatic drive(stim_t s);
        run_req        = s.run;
        halt_req       = s.halt;
        step_req       = s.step;
        soft_rst_req   = s.srst;
        cpu_instr_done = s.done;
        cpu_pc         = s.pc;
    endtask

    task automatic push(stim_t s, logic [4:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        logic [4:0] got, want;
        int i;
        drive('0);
        bp_valid = 1'b0;
        bp_addr  = '0;
        rst      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            got  = {state, cpu_rst, cpu_en, bp_hit};
            want = ex(RESET_HOLD, 1, 0, 0);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_low[%0d]: got %b want %b", k, got, want);
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) push(mk(0,0,0,0,0,0), ex(RESET_HOLD, 1, 0, 0));
        push(mk(0,0,0,0,0,0), ex(HALTED, 0, 0, 0));
        push(mk(0,0,0,0,0,0), ex(HALTED, 0, 0, 0));
        i = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            got  = {state, cpu_rst, cpu_en, bp_hit};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %b want %b", i, got, want);
            end
            i++;
        end
        drive('0);
    endtask

    task automatic test_step();
        logic [4:0] got, want;
        int i;
        push(mk(0,0,1,0,0,0), ex(STEPPING, 0, 1, 0));
        push(mk(0,0,0,0,0,0), ex(STEPPING, 0, 1, 0));
        push(mk(0,0,0,0,0,0), ex(STEPPING, 0, 1, 0));
        push(mk(0,0,0,0,1,0), ex(HALTED, 0, 0, 0));
        push(mk(0,0,0,0,0,0), ex(HALTED, 0, 0, 0));
        push(mk(0,0,0,0,1,0), ex(HALTED, 0, 0, 0));
        push(mk(0,0,0,0,0,0), ex(HALTED, 0, 0, 0));
        i = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            got  = {state, cpu_rst, cpu_en, bp_hit};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL step[%0d]: got %b want %b", i, got, want);
            end
            i++;
        end
        drive('0);
    endtask

    task automatic test_breakpoint();
        logic [4:0] got, want;
        int i;
        bp_valid = 1'b1;
        bp_addr  = 16'h0010;
        push(mk(1,0,0,0,0,16'h0000), ex(RUNNING, 0, 1, 0));
        push(mk(0,0,0,0,0,16'h0000), ex(RUNNING, 0, 1, 0));
        push(mk(0,0,0,0,1,16'h000C), ex(RUNNING, 0, 1, 0));
        push(mk(0,0,0,0,0,16'h000C), ex(RUNNING, 0, 1, 0));
        push(mk(0,0,0,0,1,16'h0010), ex(HALTED, 0, 0, 1));
        push(mk(0,0,0,0,0,16'h0010), ex(HALTED, 0, 0, 1));
        push(mk(0,0,0,0,1,16'h0010), ex(HALTED, 0, 0, 1));
        push(mk(0,0,0,1,0,16'h0000), ex(RESET_HOLD, 1, 0, 1));
        for (int k = 0; k < 3; k++) push(mk(0,0,0,0,0,0), ex(RESET_HOLD, 1, 0, 1));
        push(mk(0,0,0,0,0,0), ex(HALTED, 0, 0, 1));
        push(mk(1,0,0,0,0,0), ex(RUNNING, 0, 1, 0));
        i = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            got  = {state, cpu_rst, cpu_en, bp_hit};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL bp[%0d]: got %b want %b", i, got, want);
            end
            i++;
        end
        drive('0);
    endtask

    task automatic test_halt_run();
        logic [4:0] got, want;
        int i;
        push(mk(1,1,0,0,0,0), ex(RUNNING, 0, 1, 0));
        push(mk(0,0,0,0,0,0), ex(RUNNING, 0, 1, 0));
        push(mk(0,0,0,0,1,0), ex(HALTED, 0, 0, 0));
        push(mk(0,1,0,0,0,0), ex(HALTED, 0, 0, 0));
        push(mk(1,0,1,0,0,0), ex(STEPPING, 0, 1, 0));
        push(mk(0,1,1,0,0,0), ex(STEPPING, 0, 1, 0));
        push(mk(0,0,0,0,1,16'h0010), ex(HALTED, 0, 0, 0));
        push(mk(0,0,0,0,0,0), ex(HALTED, 0, 0, 0));
        i = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            got  = {state, cpu_rst, cpu_en, bp_hit};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL halt_run[%0d]: got %b want %b", i, got, want);
            end
            i++;
        end
        drive('0);
        bp_valid = 1'b0;
    endtask

    task automatic test_soft_rst();
        logic [4:0] got, want;
        int i;
        push(mk(0,0,1,0,0,0), ex(STEPPING, 0, 1, 0));
        push(mk(0,0,0,0,0,0), ex(STEPPING, 0, 1, 0));
        push(mk(0,0,0,1,0,0), ex(RESET_HOLD, 1, 0, 0));
        for (int k = 0; k < 3; k++) push(mk(0,0,0,0,0,0), ex(RESET_HOLD, 1, 0, 0));
        push(mk(0,0,0,0,0,0), ex(HALTED, 0, 0, 0));
        i = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            got  = {state, cpu_rst, cpu_en, bp_hit};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL soft_rst[%0d]: got %b want %b", i, got, want);
            end
            i++;
        end
        drive('0);
    endtask

    task automatic test_instr_cnt();
`ifdef CPU_RUN_CTRL_INSTR_CNT_EN
        logic [4:0] got, want;
        int i;
        push(mk(1,0,0,0,0,0), ex(RUNNING, 0, 1, 0));
        for (int k = 0; k < 5; k++) push(mk(0,0,0,0,1,0), ex(RUNNING, 0, 1, 0));
        push(mk(0,0,0,0,0,0), ex(RUNNING, 0, 1, 0));
        i = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            got  = {state, cpu_rst, cpu_en, bp_hit};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL instr_cnt_st[%0d]: got %b want %b", i, got, want);
            end
            i++;
        end
        n_checks++;
        if (instr_count !== 32'd5) begin
            n_fail++;
            $display("FAIL instr_cnt_five: got %0d want 5", instr_count);
        end
        drive(mk(0,0,0,1,0,0));
        @(posedge clk); #1;
        n_checks++;
        if (instr_count !== 32'd0) begin
            n_fail++;
            $display("FAIL instr_cnt_clear: got %0d want 0", instr_count);
        end
        drive('0);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL instr_cnt_rehalt: got %0d want 1", state);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [4:0] got, want;
        int i;
        push(mk(1,0,0,0,0,0), ex(RUNNING, 0, 1, 0));
        push(mk(0,1,0,0,0,0), ex(RUNNING, 0, 1, 0));
        push(mk(0,1,0,1,1,0), ex(RESET_HOLD, 1, 0, 0));
        for (int k = 0; k < 3; k++) push(mk(0,0,0,0,0,0), ex(RESET_HOLD, 1, 0, 0));
        push(mk(0,0,0,0,0,0), ex(HALTED, 0, 0, 0));
        push(mk(1,0,0,0,0,0), ex(RUNNING, 0, 1, 0));
        push(mk(0,0,0,0,1,0), ex(RUNNING, 0, 1, 0));
        push(mk(0,1,0,0,0,0), ex(RUNNING, 0, 1, 0));
        push(mk(0,0,0,0,1,0), ex(HALTED, 0, 0, 0));
        i = 0;
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            @(posedge clk); #1;
            got  = {state, cpu_rst, cpu_en, bp_hit};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, got, want);
            end
            i++;
        end
        drive('0);
    endtask

    initial begin
        test_reset();
        test_step();
        test_breakpoint();
        test_halt_run();
        test_soft_rst();
        test_instr_cnt();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
